// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin arbiter: requester count,
// index width, FSM state encodings and a one-hot to index helper.
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  // One-hot (or zero) vector to binary index; zero maps to 0.
  function automatic logic [ID_W-1:0] oh2id(input logic [N_REQ-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (oh[i]) id = id | ID_W'(i);
    return id;
  endfunction
endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin winner select. Lowest eligible bit at
// or above ptr, else lowest eligible bit overall. Bits in excl never win.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win,
  output logic             vld
);
  logic [N_REQ-1:0] elig, ge_ptr, hi, src;

  genvar i;
  generate
    for (i = 0; i < N_REQ; i++) begin : g_mask
      assign ge_ptr[i] = (ID_W'(i) >= ptr);
    end
  endgenerate

  assign elig = req & ~excl;
  assign hi   = elig & ge_ptr;

  // Isolate the lowest set bit of the upper window, falling back to wrap.
  always_comb begin
    src = (|hi) ? hi : elig;
    win = src & (~src + N_REQ'(1));
    vld = |elig;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: 8-way round-robin arbiter with ownership tenure.
// Define RR_ARBITER_TIMEOUT_EN to bound tenure to HOLD_MAX cycles; without it
// an owner keeps the grant for as long as it requests and expired is 0.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic             expired
);
  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 31) begin : g_bad_hold
      $error("rr_arbiter: HOLD_MAX must be in 2..31");
    end
  endgenerate

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] win, excl;
  logic             win_vld, own_req, issue;

  // The current owner never competes in its own handoff.
  assign excl    = (state_q == OWN) ? grant_q : '0;
  assign own_req = |(req & grant_q);

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .excl (excl),
    .win  (win),
    .vld  (win_vld)
  );

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [4:0] cnt_q, cnt_d;
  logic       exp_q, exp_d;
  logic       tmo;
  // Last cycle of a full tenure: the next edge completes HOLD_MAX OWN cycles.
  assign tmo = (state_q == OWN) && (cnt_q == 5'(HOLD_MAX - 1));
`endif

  // Next-state: grant on idle, hold while owner requests, hand off on release
  // (or forced rotation) in the same edge.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    issue   = 1'b0;
`ifdef RR_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
`endif
    if (state_q == IDLE) begin
      issue = win_vld;
    end else if (!own_req) begin
      if (win_vld) issue = 1'b1;
      else begin
        state_d = IDLE;
        grant_d = '0;
`ifdef RR_ARBITER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
`ifdef RR_ARBITER_TIMEOUT_EN
    end else if (tmo) begin
      if (win_vld) begin
        issue = 1'b1;
        exp_d = 1'b1;
      end else begin
        cnt_d = '0;
      end
    end else begin
      cnt_d = cnt_q + 5'd1;
`endif
    end
    if (issue) begin
      state_d = OWN;
      grant_d = win;
      ptr_d   = oh2id(win) + ID_W'(1);
`ifdef RR_ARBITER_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  // Tenure counter and one-cycle expiry pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end
  assign expired = exp_q;
`else
  assign expired = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = oh2id(grant_q);
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (HOLD_MAX=4). Expected values are hand-derived;
// tenure expectations follow RR_ARBITER_TIMEOUT_EN when it is defined.
module tb_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       expired;

  int n_chk = 0;
  int n_err = 0;

  rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [7:0] g, input logic [2:0] id, input logic ex);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".gv"},    32'(grant_valid), 32'(|g));
    chk({tag, ".gid"},   32'(grant_id), 32'(id));
    chk({tag, ".exp"},   32'(expired), 32'(ex));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    #12;
    chk_g("reset", 8'h00, 3'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk_g("idle", 8'h00, 3'd0, 1'b0);

    // First grant after reset: ptr=0, lowest of 0b110 is bit1.
    req = 8'b0000_0110; step();
    chk_g("first", 8'h02, 3'd1, 1'b0);
    step();
    chk_g("hold", 8'h02, 3'd1, 1'b0);
    // Owner drops: same-edge handoff to bit2, ptr becomes 3.
    req = 8'b0000_0100; step();
    chk_g("handoff", 8'h04, 3'd2, 1'b0);
    req = 8'h00; step();
    chk_g("to_idle", 8'h00, 3'd0, 1'b0);
    // ptr=3 picks bit3 over bit1.
    req = 8'b0000_1010; step();
    chk_g("ptr3", 8'h08, 3'd3, 1'b0);
    // Owner 3 drops while bit5 arrives the same edge; ptr=4 -> bit5.
    req = 8'b0010_0010; step();
    chk_g("new_same_edge", 8'h20, 3'd5, 1'b0);
    // Others pending must not disturb the owner (short of HOLD_MAX).
    req = 8'b0010_0011; step();
    chk_g("hold_others", 8'h20, 3'd5, 1'b0);
    // Owner 5 drops; ptr=6 -> bit7 beats bit0.
    req = 8'b1000_0001; step();
    chk_g("to7", 8'h80, 3'd7, 1'b0);
    // Owner 7 drops; wrap to bit0.
    req = 8'b0000_0001; step();
    chk_g("wrap", 8'h01, 3'd0, 1'b0);
    req = 8'h00; step();
    chk_g("idle2", 8'h00, 3'd0, 1'b0);

    // Mid-tenure asynchronous reset.
    req = 8'b0010_0000; step();
    chk_g("own5", 8'h20, 3'd5, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_g("async_rst", 8'h00, 3'd0, 1'b0);
    req = 8'b0010_0100;
    step();
    rst_n = 1'b1;
    step();
    chk_g("post_rst", 8'h04, 3'd2, 1'b0);

    // Tenure: get owner 0, then keep bit3 pending.
    req = 8'h00; step();
    req = 8'b0000_0001; step();
    chk_g("own0", 8'h01, 3'd0, 1'b0);
    req = 8'b0000_1001;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_g($sformatf("ten%0d", k), 8'h01, 3'd0, 1'b0);
    end
    step();
`ifdef RR_ARBITER_TIMEOUT_EN
    chk_g("expire", 8'h08, 3'd3, 1'b1);
    step();
    chk_g("exp_pulse", 8'h08, 3'd3, 1'b0);
    // Lone owner past HOLD_MAX keeps grant, no pulse.
    req = 8'b0000_1000;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_g($sformatf("lone%0d", k), 8'h08, 3'd3, 1'b0);
    end
`else
    chk_g("no_expire", 8'h01, 3'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_g($sformatf("unbounded%0d", k), 8'h01, 3'd0, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
